// File: rtl/thumb_pkg.sv
// Shared encodings for the thumb_core slice: FSM states, ALU ops, opcode prefixes, condition codes.
package thumb_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MOV = 2'd2
  } alu_op_t;

  // Opcode prefixes, compared against the top bits of the instruction
  localparam logic [4:0] OP_MOVS  = 5'b00100;
  localparam logic [4:0] OP_CMP   = 5'b00101;
  localparam logic [4:0] OP_ADDI  = 5'b00110;
  localparam logic [4:0] OP_SUBI  = 5'b00111;
  localparam logic [6:0] OP_ADDR  = 7'b0001100;
  localparam logic [6:0] OP_SUBR  = 7'b0001101;
  localparam logic [4:0] OP_STR   = 5'b01100;
  localparam logic [4:0] OP_LDR   = 5'b01101;
  localparam logic [3:0] OP_BCOND = 4'b1101;
  localparam logic [4:0] OP_B     = 5'b11100;
  localparam logic [7:0] OP_SVC   = 8'b11011111;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;

  // Returns {recognised, taken} for a branch condition field
  function automatic logic [1:0] cond_eval(input logic [3:0] cc, input logic n,
                                           input logic z, input logic v);
    logic gt;
    gt = ~z & (n == v);
    case (cc)
      CC_EQ:   cond_eval = {1'b1, z};
      CC_NE:   cond_eval = {1'b1, ~z};
      CC_GE:   cond_eval = {1'b1, n == v};
      CC_LT:   cond_eval = {1'b1, n != v};
      CC_GT:   cond_eval = {1'b1, gt};
      CC_LE:   cond_eval = {1'b1, ~gt};
      default: cond_eval = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/thumb_alu.sv
// Combinational ALU: add, subtract (NOT-borrow carry) and move, with NZCV outputs.
module thumb_alu
  import thumb_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v
);

  logic [32:0] wide;

  // Result and flag generation
  always_comb begin
    wide   = 33'b0;
    result = b;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      ALU_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[31:0];
        c      = wide[32];
        v      = (a[31] == b[31]) && (result[31] != a[31]);
      end
      ALU_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[31:0];
        c      = ~wide[32];
        v      = (a[31] != b[31]) && (result[31] != a[31]);
      end
      default: result = b;
    endcase
    n = result[31];
    z = (result == 32'b0);
  end

endmodule

// File: rtl/thumb_core.sv
// Multi-cycle Thumb-subset core: fetch / execute / memory over a single req/ack port.
module thumb_core
  import thumb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned SVC_HALT = 100
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              svc_valid,
  output logic [7:0]        svc_imm,
  output logic              halted,
  output logic              fault
);

  localparam int unsigned PC_W = ADDR_W + 1;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [31:0]       regs [8];
  logic [3:0]        nzcv;
  logic [15:0]       instr;

  logic [15:0]       fetch_half;
  logic              fetch_svc;
  alu_op_t           alu_op;
  logic [31:0]       alu_a, alu_b, alu_res;
  logic              alu_n, alu_z, alu_c, alu_v;
  logic [2:0]        rd;
  logic              wr_rd, wr_nz, wr_cv;
  logic              is_mem, is_str, is_branch, br_taken, is_halt_svc, illegal;
  logic [31:0]       br_off;
  logic [1:0]        cc;
  logic [ADDR_W-1:0] data_addr;
  logic [PC_W-1:0]   pc_inc, pc_next;
  logic [3:0]        nzcv_upd;

  assign fetch_half = pc[0] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign fetch_svc  = (fetch_half[15:8] == OP_SVC) && (fetch_half[7:0] != 8'(SVC_HALT));
  assign data_addr  = ADDR_W'(regs[instr[5:3]] + 32'(instr[10:6]));
  assign pc_inc     = pc + PC_W'(1);
  assign pc_next    = (is_branch && br_taken) ? pc_inc + PC_W'(br_off) : pc_inc;
  assign nzcv_upd   = {alu_n, alu_z, wr_cv ? alu_c : nzcv[1], wr_cv ? alu_v : nzcv[0]};

  thumb_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .n      (alu_n),
    .z      (alu_z),
    .c      (alu_c),
    .v      (alu_v)
  );

  // Instruction decode for the EXEC cycle
  always_comb begin
    alu_op      = ALU_ADD;
    alu_a       = regs[instr[10:8]];
    alu_b       = {24'b0, instr[7:0]};
    rd          = instr[10:8];
    wr_rd       = 1'b0;
    wr_nz       = 1'b0;
    wr_cv       = 1'b0;
    is_mem      = 1'b0;
    is_str      = 1'b0;
    is_branch   = 1'b0;
    br_taken    = 1'b0;
    br_off      = 32'b0;
    is_halt_svc = 1'b0;
    illegal     = 1'b0;
    cc          = cond_eval(instr[11:8], nzcv[3], nzcv[2], nzcv[0]);
    if (instr[15:11] == OP_MOVS) begin
      alu_op = ALU_MOV;
      wr_rd  = 1'b1;
      wr_nz  = 1'b1;
    end else if (instr[15:11] == OP_CMP) begin
      alu_op = ALU_SUB;
      wr_nz  = 1'b1;
      wr_cv  = 1'b1;
    end else if (instr[15:11] == OP_ADDI || instr[15:11] == OP_SUBI) begin
      alu_op = instr[11] ? ALU_SUB : ALU_ADD;
      wr_rd  = 1'b1;
      wr_nz  = 1'b1;
      wr_cv  = 1'b1;
    end else if (instr[15:9] == OP_ADDR || instr[15:9] == OP_SUBR) begin
      alu_op = instr[9] ? ALU_SUB : ALU_ADD;
      alu_a  = regs[instr[5:3]];
      alu_b  = regs[instr[8:6]];
      rd     = instr[2:0];
      wr_rd  = 1'b1;
      wr_nz  = 1'b1;
      wr_cv  = 1'b1;
    end else if (instr[15:11] == OP_STR || instr[15:11] == OP_LDR) begin
      is_mem = 1'b1;
      is_str = ~instr[11];
    end else if (instr[15:8] == OP_SVC) begin
      is_halt_svc = (instr[7:0] == 8'(SVC_HALT));
    end else if (instr[15:12] == OP_BCOND) begin
      if (cc[1]) begin
        is_branch = 1'b1;
        br_taken  = cc[0];
        br_off    = {{24{instr[7]}}, instr[7:0]};
      end else begin
        illegal = 1'b1;
      end
    end else if (instr[15:11] == OP_B) begin
      is_branch = 1'b1;
      br_taken  = 1'b1;
      br_off    = {{21{instr[10]}}, instr[10:0]};
    end else begin
      illegal = 1'b1;
    end
  end

  // Core FSM, architectural state and registered memory/status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_FETCH;
      pc        <= PC_W'(RESET_PC);
      nzcv      <= 4'b0;
      instr     <= 16'b0;
      for (int i = 0; i < 8; i++) regs[i] <= 32'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'b0;
      svc_valid <= 1'b0;
      svc_imm   <= 8'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      svc_valid <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= pc[ADDR_W:1];
            mem_wdata <= 32'b0;
          end else if (mem_ack) begin
            instr   <= fetch_half;
            mem_req <= 1'b0;
            state   <= ST_EXEC;
            if (fetch_svc) begin
              svc_valid <= 1'b1;
              svc_imm   <= fetch_half[7:0];
            end
          end
        end
        ST_EXEC: begin
          if (illegal) begin
            fault  <= 1'b1;
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (is_halt_svc) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            pc      <= pc_next;
            mem_req <= 1'b1;
            if (wr_rd) regs[rd] <= alu_res;
            if (wr_nz) nzcv <= nzcv_upd;
            if (is_mem) begin
              mem_we    <= is_str;
              mem_addr  <= data_addr;
              mem_wdata <= is_str ? regs[instr[2:0]] : 32'b0;
              state     <= ST_MEM;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= pc_next[ADDR_W:1];
              mem_wdata <= 32'b0;
              state     <= ST_FETCH;
            end
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            if (!mem_we) regs[instr[2:0]] <= mem_rdata;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'b0;
            state     <= ST_FETCH;
          end
        end
        default: begin
          mem_req <= 1'b0;
          halted  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thumb_core.sv
// Scoreboard bench for thumb_core: memory responder, write/SVC monitors, directed programs.
module tb_thumb_core;

  logic        clock;
  logic        reset;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        svc_valid;
  logic [7:0]  svc_imm;
  logic        halted, fault;

  thumb_core dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .svc_valid (svc_valid),
    .svc_imm   (svc_imm),
    .halted    (halted),
    .fault     (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] mem [1024];
  wr_t         wr_q [$];
  logic [7:0]  svc_q [$];
  int          tests = 0;
  int          fails = 0;
  int          wait_n = 0;
  bit          hold_resp = 1'b0;
  bit          stall_en = 1'b0;
  int          stall_addr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [15:0] i8(input logic [4:0] op, input int r, input int imm);
    return {op, 3'(r), 8'(imm)};
  endfunction
  function automatic logic [15:0] rr(input bit sub, input int d, input int n, input int m);
    return {6'b000110, sub, 3'(m), 3'(n), 3'(d)};
  endfunction
  function automatic logic [15:0] ls(input bit ldr, input int t, input int n, input int imm);
    return {4'b0110, ldr, 5'(imm), 3'(n), 3'(t)};
  endfunction
  function automatic logic [15:0] bc(input int cond, input int imm);
    return {4'b1101, 4'(cond), 8'(imm)};
  endfunction
  function automatic logic [15:0] bu(input int imm);
    return {5'b11100, 11'(imm)};
  endfunction
  function automatic logic [15:0] svc(input int imm);
    return {8'hDF, 8'(imm)};
  endfunction

  task automatic put(input int hw, input logic [15:0] v);
    mem[hw / 2][16 * (hw % 2) +: 16] = v;
  endtask

  task automatic exp_wr(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = 10'(a);
    e.data = d;
    wr_q.push_back(e);
  endtask

  // Memory responder with programmable wait states and an optional never-acked address
  initial begin : responder
    int cnt;
    logic [42:0] cap;
    cnt = 0;
    cap = '0;
    mem_ack = 1'b0;
    mem_rdata = 32'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!hold_resp) begin
        mem_ack = 1'b0;
        if (reset || !mem_req) begin
          cnt = 0;
        end else if (stall_en && !mem_we && mem_addr == 10'(stall_addr)) begin
          cnt = 0;
        end else if (cnt == 0 && wait_n > 0) begin
          cap = {mem_we, mem_addr, mem_wdata};
          cnt = 1;
        end else if (cnt > 0 && cnt < wait_n) begin
          check("req_stable", 64'({mem_we, mem_addr, mem_wdata}), 64'(cap));
          cnt++;
        end else begin
          if (cnt > 0) check("req_stable", 64'({mem_we, mem_addr, mem_wdata}), 64'(cap));
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
          if (mem_we) mem[mem_addr] = mem_wdata;
          cnt = 0;
        end
      end
    end
  end

  // Monitor: compare completed writes and SVC pulses against the scoreboard queues
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_req && mem_we && mem_ack) begin
        if (wr_q.size() == 0) begin
          check("wr_extra", 64'(mem_addr), 64'hFFFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(e.addr));
          check("wr_data", 64'(mem_wdata), 64'(e.data));
        end
      end
      if (svc_valid) begin
        if (svc_q.size() == 0) check("svc_extra", 64'(svc_imm), 64'hFFFF);
        else check("svc_imm", 64'(svc_imm), 64'(svc_q.pop_front()));
      end
    end
  end

  // Hold reset, check reset outputs, clear memory and scoreboard
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    hold_resp = 1'b0;
    stall_en = 1'b0;
    wait_n = 0;
    @(posedge clock);
    #1;
    check("rst_outs", 64'({mem_req, mem_we, mem_addr, mem_wdata, svc_valid, svc_imm, halted, fault}),
          64'h0);
    check("rst_pc", 64'(dut.pc), 64'h0);
    for (int i = 0; i < 1024; i++) mem[i] = 32'b0;
    wr_q.delete();
    svc_q.delete();
  endtask

  // Release reset and run until halted, bounded
  task automatic run(input int budget);
    int cyc;
    cyc = 0;
    @(negedge clock);
    reset = 1'b0;
    while (!halted && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    check("halt_reached", 64'(halted), 64'h1);
    repeat (3) @(negedge clock);
    check("wr_q_empty", 64'(wr_q.size()), 64'h0);
    check("svc_q_empty", 64'(svc_q.size()), 64'h0);
  endtask

  initial begin : main
    int cyc;
    int reqs;
    reset = 1'b1;

    // MOVS/ADDS/SVC
    do_reset();
    put(0, i8(5'b00100, 0, 2));
    put(1, i8(5'b00110, 0, 1));
    put(2, svc(0));
    put(3, ls(1'b0, 0, 7, 16));
    put(4, svc(100));
    svc_q.push_back(8'h00);
    exp_wr(16, 32'd3);
    run(300);
    check("a_nzcv", 64'(dut.nzcv), 64'h0);
    check("a_fault", 64'(fault), 64'h0);

    // Signed overflow on ADDS of a loaded 0x7FFFFFFF
    do_reset();
    mem[31] = 32'h7FFF_FFFF;
    put(0, ls(1'b1, 1, 7, 31));
    put(1, i8(5'b00110, 1, 1));
    put(2, ls(1'b0, 1, 7, 30));
    put(3, svc(100));
    exp_wr(30, 32'h8000_0000);
    run(300);
    check("b_nzcv", 64'(dut.nzcv), 64'b1001);

    // CMP + BEQ taken, BNE not taken
    do_reset();
    put(0, i8(5'b00100, 2, 5));
    put(1, i8(5'b00101, 2, 5));
    put(2, bc(0, 2));
    put(3, i8(5'b00100, 3, 8'hAA));
    put(4, i8(5'b00100, 3, 8'hBB));
    put(5, bc(1, 3));
    put(6, ls(1'b0, 2, 7, 20));
    put(7, ls(1'b0, 3, 7, 21));
    put(8, svc(100));
    exp_wr(20, 32'd5);
    exp_wr(21, 32'd0);
    run(300);
    check("c_nzcv", 64'(dut.nzcv), 64'b0110);
    check("c_pc", 64'(dut.pc), 64'd8);

    // Backward loop, register ADDS/SUBS, LT taken, GT not taken, B imm11
    do_reset();
    put(0, i8(5'b00100, 0, 3));
    put(1, i8(5'b00100, 1, 0));
    put(2, i8(5'b00110, 1, 5));
    put(3, i8(5'b00111, 0, 1));
    put(4, bc(1, -3));
    put(5, i8(5'b00100, 2, 7));
    put(6, rr(1'b1, 3, 1, 2));
    put(7, rr(1'b0, 4, 3, 1));
    put(8, i8(5'b00101, 2, 9));
    put(9, bc(11, 1));
    put(10, svc(1));
    put(11, bc(12, 0));
    put(12, bu(1));
    put(13, svc(2));
    put(14, ls(1'b0, 4, 7, 24));
    put(15, ls(1'b0, 1, 7, 25));
    put(16, svc(9));
    put(17, svc(100));
    exp_wr(24, 32'd23);
    exp_wr(25, 32'd15);
    svc_q.push_back(8'd9);
    run(600);
    check("d_nzcv", 64'(dut.nzcv), 64'b1000);

    // Store address wraps to word 0, every access held for 3 wait cycles
    do_reset();
    mem[31] = 32'h0000_03FF;
    put(0, ls(1'b1, 4, 7, 31));
    put(1, i8(5'b00100, 3, 8'h5A));
    put(2, ls(1'b0, 3, 4, 1));
    put(3, svc(100));
    exp_wr(0, 32'h5A);
    wait_n = 3;
    run(600);

    // Unrecognised 0xFFFF: fault, halt, no further requests, reset clears
    do_reset();
    put(0, i8(5'b00100, 0, 1));
    put(1, 16'hFFFF);
    run(300);
    check("f_fault", 64'(fault), 64'h1);
    check("f_pc", 64'(dut.pc), 64'd1);
    check("f_r0", 64'(dut.regs[0]), 64'd1);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (mem_req) reqs++;
    end
    check("f_no_req", 64'(reqs), 64'h0);
    do_reset();
    check("f_rst_fault", 64'(fault), 64'h0);

    // Unrecognised condition field 1110
    do_reset();
    put(0, 16'hDE05);
    run(300);
    check("g_fault", 64'(fault), 64'h1);
    check("g_pc", 64'(dut.pc), 64'd0);

    // Reset during a stalled LDR; a late ack in the reset cycle is discarded
    do_reset();
    put(0, i8(5'b00100, 5, 8'h77));
    put(1, ls(1'b1, 5, 7, 3));
    stall_en = 1'b1;
    stall_addr = 3;
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;
    while (!(mem_req && !mem_we && mem_addr == 10'd3) && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("h_ldr_pending", 64'(mem_req && mem_addr == 10'd3), 64'h1);
    repeat (2) @(negedge clock);
    hold_resp = 1'b1;
    reset = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    mem_ack = 1'b1;
    @(posedge clock);
    #1;
    check("h_req_drop", 64'(mem_req), 64'h0);
    check("h_r5", 64'(dut.regs[5]), 64'h0);
    check("h_pc", 64'(dut.pc), 64'h0);
    @(negedge clock);
    mem_ack = 1'b0;
    hold_resp = 1'b0;
    @(negedge clock);
    check("h_r5_after", 64'(dut.regs[5]), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
